// File: rtl/stream_fifo_pkg.sv
// Shared width helpers and DEPTH legality check for the stream_fifo block.
package stream_fifo_pkg;

   // Pointer width; a single-entry array would still need one address bit.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy must represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit depth_is_legal(input int unsigned depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH_BITS storage: one synchronous write port, one asynchronous read port.
module stream_fifo_mem
   import stream_fifo_pkg::*;
#(
   parameter int unsigned WIDTH_BITS = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                           i_clock,
   input  logic                           i_we,
   input  logic [ptr_width(DEPTH)-1:0]    i_waddr,
   input  logic [WIDTH_BITS-1:0]          i_wdata,
   input  logic [ptr_width(DEPTH)-1:0]    i_raddr,
   output logic [WIDTH_BITS-1:0]          o_rdata
);

   logic [WIDTH_BITS-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with registered output stage; DEPTH counts the output register.
// Define STREAM_FIFO_COUNT_EN to expose the occupancy port 'count'.
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int unsigned WIDTH_BITS = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    input_valid,
   output logic                    input_ready,
   input  logic [WIDTH_BITS-1:0]   input_data,
   output logic                    output_valid,
   input  logic                    output_ready,
   output logic [WIDTH_BITS-1:0]   output_data
`ifdef STREAM_FIFO_COUNT_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

   localparam int unsigned PtrW = ptr_width(DEPTH);
   localparam int unsigned CntW = cnt_width(DEPTH);

   if (!depth_is_legal(DEPTH)) begin : g_bad_depth
      $error("stream_fifo: DEPTH must be a power of two and at least 2");
   end
   if (WIDTH_BITS < 1) begin : g_bad_width
      $error("stream_fifo: WIDTH_BITS must be at least 1");
   end

   logic [PtrW-1:0]       r_wr_ptr, w_wr_ptr_next;
   logic [PtrW-1:0]       r_rd_ptr, w_rd_ptr_next;
   logic [CntW-1:0]       r_count, w_count_next;
   logic                  r_valid, w_valid_next;
   logic [WIDTH_BITS-1:0] r_data, w_data_next;

   logic                  w_push, w_pop, w_we;
   logic [PtrW-1:0]       w_rd_addr;
   logic [WIDTH_BITS-1:0] w_rd_data;

   assign input_ready  = (r_count != CntW'(DEPTH));
   assign output_valid = r_valid;
   assign output_data  = r_data;

   assign w_push    = input_valid && input_ready;
   assign w_pop     = r_valid && output_ready;
   assign w_we      = w_push && !flush;
   // The array keeps every entry, including the one mirrored in r_data,
   // so the successor of the head always lives at rd_ptr + 1.
   assign w_rd_addr = r_rd_ptr + PtrW'(1);

`ifdef STREAM_FIFO_COUNT_EN
   assign count = r_count;
`endif

   stream_fifo_mem #(
      .WIDTH_BITS (WIDTH_BITS),
      .DEPTH      (DEPTH)
   ) u_mem (
      .i_clock (clock),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (input_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   always_comb begin
      w_wr_ptr_next = r_wr_ptr;
      w_rd_ptr_next = r_rd_ptr;
      w_count_next  = r_count;
      w_valid_next  = r_valid;
      w_data_next   = r_data;
      if (flush) begin
         w_wr_ptr_next = '0;
         w_rd_ptr_next = '0;
         w_count_next  = '0;
         w_valid_next  = 1'b0;
      end else begin
         if (w_push) begin
            w_wr_ptr_next = r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + PtrW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CntW'(1);
            2'b01:   w_count_next = r_count - CntW'(1);
            default: w_count_next = r_count;
         endcase
         // Refill the output register with whatever becomes the new head.
         if (w_pop) begin
            if (r_count >= CntW'(2)) begin
               w_valid_next = 1'b1;
               w_data_next  = w_rd_data;
            end else if (w_push) begin
               w_valid_next = 1'b1;
               w_data_next  = input_data;
            end else begin
               w_valid_next = 1'b0;
            end
         end else if (w_push && !r_valid) begin
            w_valid_next = 1'b1;
            w_data_next  = input_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
      end else begin
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
         r_valid  <= w_valid_next;
         r_data   <= w_data_next;
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed table on DEPTH=4, random traffic on DEPTH=8.
// Occupancy checks are included when STREAM_FIFO_COUNT_EN is defined.
module tb_stream_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=4 instance for directed vectors
   logic       rst4, fl4, iv4, ir4, ov4, or4;
   logic [7:0] id4, od4;
   // DEPTH=8 instance for random traffic
   logic       rst8, fl8, iv8, ir8, ov8, or8;
   logic [7:0] id8, od8;
`ifdef STREAM_FIFO_COUNT_EN
   logic [2:0] cnt4;
   logic [3:0] cnt8;
`endif

   stream_fifo #(
      .WIDTH_BITS (8),
      .DEPTH      (4)
   ) u_dut4 (
      .clock        (clk),
      .reset        (rst4),
      .flush        (fl4),
      .input_valid  (iv4),
      .input_ready  (ir4),
      .input_data   (id4),
      .output_valid (ov4),
      .output_ready (or4),
      .output_data  (od4)
`ifdef STREAM_FIFO_COUNT_EN
      ,
      .count        (cnt4)
`endif
   );

   stream_fifo #(
      .WIDTH_BITS (8),
      .DEPTH      (8)
   ) u_dut8 (
      .clock        (clk),
      .reset        (rst8),
      .flush        (fl8),
      .input_valid  (iv8),
      .input_ready  (ir8),
      .input_data   (id8),
      .output_valid (ov8),
      .output_ready (or8),
      .output_data  (od8)
`ifdef STREAM_FIFO_COUNT_EN
      ,
      .count        (cnt8)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       flush;
      logic       iv;
      logic [7:0] din;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic [7:0] e_od;
      int         e_cnt;
   } vec_t;

   vec_t vecs[24];

   initial begin
      logic [7:0] q[$];
      int         pops;
      int         cyc;
      int         rdy_pct;
      bit         push, pop;

      // Each row: inputs applied for one edge, outputs expected right after it.
      vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1};
      vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1};
      vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
      vecs[4]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 8'hA0, 1};
      vecs[5]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0, 2};
      vecs[6]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 3};
      vecs[7]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      vecs[8]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      vecs[9]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
      vecs[10] = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA1, 3};
      vecs[11] = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 4};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 2};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 1};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
      vecs[16] = '{1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hB0, 1};
      vecs[17] = '{1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB0, 2};
      vecs[18] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 0};
      vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
      vecs[20] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b1, 8'hC0, 1};
      vecs[21] = '{1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 8'hC1, 1};
      vecs[22] = '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 8'hC1, 2};
      vecs[23] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC1, 3};

      rst4 = 1'b1; fl4 = 1'b0; iv4 = 1'b0; id4 = 8'h00; or4 = 1'b0;
      rst8 = 1'b1; fl8 = 1'b0; iv8 = 1'b0; id8 = 8'h00; or8 = 1'b0;
      step();
      step();
      chk("reset_ov", 32'(ov4), 32'd0);
      chk("reset_od", 32'(od4), 32'h0);
`ifdef STREAM_FIFO_COUNT_EN
      chk("reset_cnt", 32'(cnt4), 32'd0);
`endif
      rst4 = 1'b0;
      rst8 = 1'b0;
      step();
      chk("post_reset_ir", 32'(ir4), 32'd1);
      chk("post_reset_ov", 32'(ov4), 32'd0);

      for (int i = 0; i < 24; i++) begin
         fl4 = vecs[i].flush;
         iv4 = vecs[i].iv;
         id4 = vecs[i].din;
         or4 = vecs[i].ordy;
         step();
         chk($sformatf("vec%0d_ir", i), 32'(ir4), 32'(vecs[i].e_ir));
         chk($sformatf("vec%0d_ov", i), 32'(ov4), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov) chk($sformatf("vec%0d_od", i), 32'(od4), 32'(vecs[i].e_od));
`ifdef STREAM_FIFO_COUNT_EN
         chk($sformatf("vec%0d_cnt", i), 32'(cnt4), 32'(vecs[i].e_cnt));
`endif
      end
      fl4 = 1'b0;

      // Reset with three entries stored; a push during reset must be dropped.
      rst4 = 1'b1; iv4 = 1'b1; id4 = 8'hEE; or4 = 1'b0;
      step();
      chk("midrst_ov", 32'(ov4), 32'd0);
      chk("midrst_od", 32'(od4), 32'h0);
      chk("midrst_ir", 32'(ir4), 32'd1);
`ifdef STREAM_FIFO_COUNT_EN
      chk("midrst_cnt", 32'(cnt4), 32'd0);
`endif
      rst4 = 1'b0; iv4 = 1'b0;
      step();
      chk("rel_ir", 32'(ir4), 32'd1);
      chk("rel_ov", 32'(ov4), 32'd0);
      iv4 = 1'b1; id4 = 8'hD0; or4 = 1'b1;
      step();
      iv4 = 1'b0;
      chk("rel_push_ov", 32'(ov4), 32'd1);
      chk("rel_push_od", 32'(od4), 32'hD0);
      step();
      chk("rel_drain_ov", 32'(ov4), 32'd0);

      // Random traffic on DEPTH=8 against a queue model.
      pops = 0;
      cyc  = 0;
      while (pops < 1000 && cyc < 20000) begin
         case ((cyc / 150) % 3)
            0:       rdy_pct = 20;
            1:       rdy_pct = 60;
            default: rdy_pct = 95;
         endcase
         iv8 = ($urandom_range(0, 99) < 75);
         id8 = 8'($urandom);
         or8 = ($urandom_range(0, 99) < rdy_pct);
         chk("rnd_ir", 32'(ir8), 32'(q.size() < 8));
         chk("rnd_ov", 32'(ov8), 32'(q.size() > 0));
         if (q.size() > 0) chk("rnd_od", 32'(od8), 32'(q[0]));
`ifdef STREAM_FIFO_COUNT_EN
         chk("rnd_cnt", 32'(cnt8), 32'(q.size()));
`endif
         push = iv8 && (q.size() < 8);
         pop  = or8 && (q.size() > 0);
         if (pop) begin
            void'(q.pop_front());
            pops++;
         end
         if (push) q.push_back(id8);
         step();
         cyc++;
      end
      chk("rnd_pops_done", 32'(pops >= 1000), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
